// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// start/busy/done handshake with a single-cycle bypass for divide special cases.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        op_reg, op_next;
  logic [XLEN:0]     acc_reg, acc_next;
  logic [XLEN-1:0]   lo_reg, lo_next;
  logic [XLEN-1:0]   mag_b_reg, mag_b_next;
  logic [XLEN-1:0]   res_reg, res_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;
  logic              busy_reg, done_reg;

  // Operand decode at request time
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
    mag_a    = a_neg ? (~a + 1'b1) : a;
    mag_b    = b_neg ? (~b + 1'b1) : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    if (div_zero) begin
      special_res = op[1] ? a : '1;
    end else begin
      special_res = op[1] ? '0 : a;
    end
  end

  // One iteration of either shift-add multiply or restoring divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_trial;
  logic [XLEN:0]     it_acc;
  logic [XLEN-1:0]   it_lo;

  always_comb begin
    mul_sum   = acc_reg + (lo_reg[0] ? {1'b0, mag_b_reg} : {(XLEN+1){1'b0}});
    div_shift = {acc_reg[XLEN-1:0], lo_reg[XLEN-1]};
    div_trial = {1'b0, div_shift} - {2'b00, mag_b_reg};
    if (op_reg[2]) begin
      if (!div_trial[XLEN+1]) begin
        it_acc = div_trial[XLEN:0];
        it_lo  = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        it_acc = div_shift;
        it_lo  = {lo_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      it_acc = {1'b0, mul_sum[XLEN:1]};
      it_lo  = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  // Final result is formed from the last iteration's outputs so it can load entering DONE
  logic [2*XLEN-1:0] product, product_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    product     = {it_acc[XLEN-1:0], it_lo};
    product_fix = neg_q_reg ? (~product + 1'b1) : product;
    quot_fix    = neg_q_reg ? (~it_lo + 1'b1) : it_lo;
    rem_fix     = neg_r_reg ? (~it_acc[XLEN-1:0] + 1'b1) : it_acc[XLEN-1:0];
    case (op_reg)
      OP_MUL:                      final_res = product_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = product_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res = quot_fix;
      default:                     final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    acc_next   = acc_reg;
    lo_next    = lo_reg;
    mag_b_next = mag_b_reg;
    res_next   = res_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next    = op;
          neg_q_next = a_neg ^ b_neg;
          neg_r_next = a_neg;
          mag_b_next = mag_b;
          acc_next   = '0;
          lo_next    = mag_a;
          cnt_next   = CNT_W'(XLEN);
          if (div_zero || div_ovf) begin
            state_next = DONE;
            res_next   = special_res;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        acc_next = it_acc;
        lo_next  = it_lo;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
          res_next   = final_res;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      acc_reg   <= '0;
      lo_reg    <= '0;
      mag_b_reg <= '0;
      res_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      acc_reg   <= acc_next;
      lo_reg    <= lo_next;
      mag_b_reg <= mag_b_next;
      res_reg   <= res_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign res  = res_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at start, compared on done.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] res;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .res(res)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total = 0;
  int   checks_passed = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, res, e.val);
        $display("op %s res=%08h exp=%08h", e.tag, res, e.val);
      end
    end
  end

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    case (o)
      3'b000: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return sp[31:0]; end
      3'b001: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return sp[63:32]; end
      3'b010: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'b0, y}); return sp[63:32]; end
      3'b011: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        return sx / sy;
      end
      3'b101: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  // Called just after a posedge; request is accepted at the next edge
  task automatic launch(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back('{tag, exp});
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic finish_op(input string tag, input int lat);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      else break;
    end
    check({tag, "_lat"}, cyc, lat);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    launch(tag, o, x, y, exp);
    finish_op(tag, lat);
    check({tag, "_dones"}, done_cnt - d0, 1);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 100) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int d0;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", res, 0);
    rst_n = 1'b1;

    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    run_op("mul_zero", 3'b000, 32'd0, 32'd5, 32'd0, 33);
    run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    run_op("remu_last", 3'b111, 32'd100, 32'd7, 32'd2, 33);

    // start held high through a whole operation
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b101; a = 32'd300; b = 32'd7;
    exp_q.push_back('{"hold_start", 32'd42});
    wait_done("hold_start");
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_start_dones", done_cnt - d0, 1);

    // start pulse during CALC is ignored; res holds old value meanwhile
    d0 = done_cnt;
    @(posedge clk); #1;
    launch("ignore_start", 3'b101, 32'd200, 32'd7, 32'd28);
    repeat (5) @(posedge clk);
    #1; start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("res_hold", res, 32'd42);
    check("busy_in_calc", busy, 1);
    wait_done("ignore_start");
    repeat (40) @(negedge clk);
    check("ignore_start_dones", done_cnt - d0, 1);

    // back-to-back: new start in the cycle after done
    d0 = done_cnt;
    @(posedge clk); #1;
    launch("b2b_first", 3'b000, 32'd6, 32'd7, 32'd42);
    wait_done("b2b_first");
    @(posedge clk); #1;
    launch("b2b_second", 3'b011, 32'h00010000, 32'h00030000, 32'd3);
    finish_op("b2b_second", 33);
    check("b2b_dones", done_cnt - d0, 2);

    // reset at CALC cycle 10 aborts the request
    d0 = done_cnt;
    @(posedge clk); #1;
    launch("aborted", 3'b000, 32'd9, 32'd9, 32'd81);
    repeat (9) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", res, 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_op("after_abort", 3'b011, 32'h00010000, 32'h00010000, 32'd1, 33);

    // randomized ops against the arithmetic model
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'd0 : $urandom;
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
